// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter.
// Contents: FSM state encoding and requester identifiers.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (fetch, load/store), the arbiter
// and the memory array.
//   master : requester/memory side (drives reqs, addresses, store data, mem_rdata)
//   slave  : arbiter side (drives acks, read data, memory strobes, busy)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational two-way round-robin pick.
// Ports:
//   req_if, req_d : raw requests
//   last_grant    : requester granted most recently (REQ_IF / REQ_D)
//   mask          : [0] ignore IF, [1] ignore D (requester currently being acked)
//   grant_valid   : at least one unmasked request
//   grant_id      : winner; on a tie, the requester that was not granted last
module mem_rr_pick
    import cpu_mem_pkg::*;
(
    input  logic       req_if,
    input  logic       req_d,
    input  logic       last_grant,
    input  logic [1:0] mask,
    output logic       grant_valid,
    output logic       grant_id
);

    logic eff_if;
    logic eff_d;

    assign eff_if = req_if & ~mask[0];
    assign eff_d  = req_d  & ~mask[1];

    always_comb begin
        grant_valid = eff_if | eff_d;
        grant_id    = REQ_IF;
        if (eff_if && eff_d) begin
            grant_id = ~last_grant;
        end else if (eff_d) begin
            grant_id = REQ_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified memory between instruction fetch (IF)
// and load/store (D) with round-robin arbitration and programmable wait
// states. Each access holds mem_en for WAIT_STATES+1 cycles, then acks
// the winner for one cycle.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : requester handshakes, read data, memory strobes, busy
//
// state  | meaning
// IDLE   | no access in flight, arbitrating raw requests
// ACCESS | mem_en high, wait counter running
// DONE   | one-cycle ack to the granted requester, re-arbitrate the other one
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic               clock,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    localparam int              CNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_STATES);

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic              load;

    // grant_id and last_grant always hold the same value, so one flop serves both.
    logic              last_grant;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic [1:0]        mask;
    logic              pick_valid;
    logic              pick_id;
    logic              last_beat;

    // While acking, the acked requester still has req high; hide it so it
    // cannot be granted twice in a row.
    assign mask = (state == DONE) ? ((last_grant == REQ_D) ? 2'b10 : 2'b01) : 2'b00;

    mem_rr_pick u_pick (
        .req_if      (bus.if_req),
        .req_d       (bus.d_req),
        .last_grant  (last_grant),
        .mask        (mask),
        .grant_valid (pick_valid),
        .grant_id    (pick_id)
    );

    assign last_beat = (state == ACCESS) && (cnt == CNT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = '0;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n = ACCESS;
                    load    = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt == CNT_LAST) begin
                    state_n = DONE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE: begin
                if (pick_valid) begin
                    state_n = ACCESS;
                    load    = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant <= REQ_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (load) begin
                last_grant <= pick_id;
                if (pick_id == REQ_IF) begin
                    addr_q <= bus.if_addr;
                    we_q   <= 1'b0;
                end else begin
                    addr_q <= bus.d_addr;
                    we_q   <= bus.d_we;
                    if (bus.d_we) begin
                        wdata_q <= bus.d_wdata;
                    end
                end
            end
            if (last_beat) begin
                if (last_grant == REQ_IF) begin
                    if_rdata_q <= bus.mem_rdata;
                end else if (!we_q) begin
                    d_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    // we_q keeps its value between accesses, so the write strobe is gated
    // by ACCESS to keep it inside mem_en.
    assign bus.mem_en    = (state == ACCESS);
    assign bus.mem_we    = (state == ACCESS) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_ack    = (state == DONE) && (last_grant == REQ_IF);
    assign bus.d_ack     = (state == DONE) && (last_grant == REQ_D);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = (state != IDLE);

endmodule
